data_sram_responder: RTL and testbench

Synchronous single-port data SRAM responder: the memory side of the `data_sram_*` interface used by the execute stage to issue accesses and by the memory stage to pick up `data_sram_rdata`. It accepts one access per cycle, applies byte-strobed writes, and returns read data with a fixed one-cycle latency. The block also provides:
- a post-reset clear sequencer,
- sticky out-of-range error detection,
- access counters for bring-up and debug.

---
 rtl/data_sram_responder.sv | 140 ++++++++++++++
 tb/tb_data_sram_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: memory side of the data_sram_* interface.
// Byte-strobed writes, one-cycle read latency, sticky out-of-range flag,
// and accepted-access counters.
// Optional feature macro: DSRAM_INIT_CLEAR_EN compiles in a post-reset
// sequencer that zeroes every word before init_done is raised.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        oob_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];

  logic [31:0]           r_rdata;
  logic                  r_init_done;
  logic                  r_oob_err;
  logic [31:0]           r_rd_count;
  logic [31:0]           r_wr_count;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_is_wr;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_rd_oob;
  logic                  w_oob;
  logic                  w_ready;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_idx;
  logic                  w_unused_addr_lsbs;

  // Address decode and access classification. Accepts are gated by resetn
  // so nothing lands in memory on a reset edge.
  assign w_idx              = data_sram_addr[ADDR_WIDTH+1:2];
  assign w_in_range         = (data_sram_addr[31:ADDR_WIDTH+2] == '0);
  assign w_accept           = data_sram_en & r_init_done & resetn;
  assign w_is_wr            = |data_sram_we;
  assign w_wr_ok            = w_accept &  w_is_wr &  w_in_range;
  assign w_rd_ok            = w_accept & ~w_is_wr &  w_in_range;
  assign w_rd_oob           = w_accept & ~w_is_wr & ~w_in_range;
  assign w_oob              = w_accept & ~w_in_range;
  assign w_unused_addr_lsbs = ^data_sram_addr[1:0];

`ifdef DSRAM_INIT_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;

  // Clear sequencer state and pointer; reset always restarts from word 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_we) r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  // Next state: sweep every word once, then stay READY until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      S_READY: w_state_nxt = S_READY;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign w_ready   = (r_state == S_READY);
  assign w_clr_idx = r_clr_ptr;
`else
  assign w_ready   = 1'b1;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  // Registered ready flag seen by the requester.
  always_ff @(posedge clk) begin
    if (!resetn) r_init_done <= 1'b0;
    else         r_init_done <= w_ready;
  end

  // Memory array: clear sweep or byte-lane merge; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= 32'h0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read data register: loads only on accepted reads, otherwise holds.
  always_ff @(posedge clk) begin
    if (!resetn)       r_rdata <= 32'h0;
    else if (w_rd_ok)  r_rdata <= r_mem[w_idx];
    else if (w_rd_oob) r_rdata <= 32'h0;
  end

  // Sticky out-of-range flag and in-range access counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_oob_err  <= 1'b0;
      r_rd_count <= 32'h0;
      r_wr_count <= 32'h0;
    end else begin
      if (w_oob)   r_oob_err  <= 1'b1;
      if (w_rd_ok) r_rd_count <= r_rd_count + 32'd1;
      if (w_wr_ok) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign data_sram_rdata = r_rdata;
  assign init_done       = r_init_done;
  assign oob_err         = r_oob_err;
  assign rd_count        = r_rd_count;
  assign wr_count        = r_wr_count;

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: directed vector table, a reference
// model of the memory and flags, randomized traffic and reset/clear timing.
module tb_data_sram_responder;

  localparam int          AW       = 12;
  localparam logic [31:0] ADDR_LIM = 32'h1 << (AW + 2);
`ifdef DSRAM_INIT_CLEAR_EN
  localparam int          EXP_LAT  = (1 << AW) + 1;
  localparam logic        EXP_MID  = 1'b0;
`else
  localparam int          EXP_LAT  = 1;
  localparam logic        EXP_MID  = 1'b1;
`endif

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_done;
  logic        oob_err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  data_sram_responder #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .oob_err         (oob_err),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  bit          m_zero_fill;
  logic [31:0] m_rdata;
  bit          m_rdata_known;
  bit          m_oob;
  bit          m_init;
  int unsigned m_rd;
  int unsigned m_wr;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_oob;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare after the edge.
  task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int          idx;
    logic [31:0] word;
    bit          known;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (en && m_init) begin
      if (addr < ADDR_LIM) begin
        idx   = int'(addr / 4);
        known = m_mem.exists(idx) || m_zero_fill;
        word  = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        if (we != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (we[b]) word[8*b +: 8] = wdata[8*b +: 8];
          if (known || we == 4'hF) m_mem[idx] = word;
          else m_mem.delete(idx);
          m_wr++;
        end else begin
          m_rdata       = word;
          m_rdata_known = known;
          m_rd++;
        end
      end else begin
        m_oob = 1'b1;
        if (we == 4'h0) begin
          m_rdata       = 32'h0;
          m_rdata_known = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("init_done", 32'(init_done), 32'(m_init));
    chk("oob_err", 32'(oob_err), 32'(m_oob));
    chk("rd_count", rd_count, m_rd);
    chk("wr_count", wr_count, m_wr);
    if (m_rdata_known) chk("rdata", data_sram_rdata, m_rdata);
  endtask

  // Hold reset for n edges, check every output is cleared, reset the model.
  task automatic do_reset(input int n);
    resetn       = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_oob_err", 32'(oob_err), 32'h0);
    chk("rst_rd_count", rd_count, 32'h0);
    chk("rst_wr_count", wr_count, 32'h0);
    m_mem.delete();
`ifdef DSRAM_INIT_CLEAR_EN
    m_zero_fill = 1'b1;
`else
    m_zero_fill = 1'b0;
`endif
    m_rdata = 32'h0; m_rdata_known = 1'b1;
    m_oob = 1'b0; m_init = 1'b0; m_rd = 0; m_wr = 0;
  endtask

  // Release reset and count edges until init_done rises (bounded).
  task automatic wait_init();
    int n;
    n = 0;
    resetn = 1'b1;
    while (n < 6000 && init_done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_latency", n, EXP_LAT);
    m_init = 1'b1;
  endtask

  initial begin
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    tbl.push_back('{1'b1, 4'hF, 32'h0000001C, 32'hDEADBEEF, 32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000001C, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 32'h00000020, 32'h11223344, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 4'h5, 32'h00000020, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 32'h00000020, 32'h0,        32'h11BB33DD, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 32'h00000024, 32'h00000001, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 32'h00000028, 32'h00000002, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 32'h00000024, 32'h0,        32'h00000001, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 32'h0000001C, 32'h12345678, 32'h00000001, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 32'h00000028, 32'h0,        32'h00000002, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 32'h00000024, 32'h0,        32'h00000002, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000001C, 32'h0,        32'h12345678, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 32'h00004000, 32'hFFFFFFFF, 32'h12345678, 1'b1});
    tbl.push_back('{1'b1, 4'h0, 32'h00004000, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 4'hF, 32'h00004020, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 4'h0, 32'h00000020, 32'h0,        32'h11BB33DD, 1'b1});
    tbl.push_back('{1'b1, 4'h0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 4'h0, 32'h0000001D, 32'h0,        32'h12345678, 1'b1});

    do_reset(3);
    wait_init();

`ifdef DSRAM_INIT_CLEAR_EN
    step(1'b1, 4'h0, 32'h00000000, 32'h0);
    step(1'b1, 4'h0, 32'h00000800, 32'h0);
    step(1'b1, 4'h0, 32'h00003FFC, 32'h0);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_rdata", i), data_sram_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_oob", i), 32'(oob_err), 32'(tbl[i].exp_oob));
    end

    // Fresh reset so the random phase can also observe the first oob event.
    do_reset(2);
    wait_init();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h00004000;
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step($urandom_range(0, 3) != 0, w, a, $urandom);
    end

    // Reset asserted 100 cycles into the clear sweep.
    do_reset(2);
    resetn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("init_mid_clear", 32'(init_done), 32'(EXP_MID));
    do_reset(2);
    wait_init();
    step(1'b1, 4'h0, 32'h0000001C, 32'h0);
    step(1'b1, 4'h0, 32'h00000020, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
